// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types and helpers for the register slave.
// Purely declarative; no state, no latency, no flow control.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_t;

  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = 4;

  function automatic logic [AXIL_DATA_W-1:0] apply_strb(
    input logic [AXIL_DATA_W-1:0] old_val,
    input logic [AXIL_DATA_W-1:0] new_val,
    input logic [AXIL_STRB_W-1:0] strb
  );
    logic [AXIL_DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < AXIL_STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_hold_reg.sv
// Single-entry holding register with full flag; load visible the cycle after the handshake.
// Backpressure: ready_o drops while full and rises again on the cycle after clear_i.
module axil_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] dat_i,
  output logic [W-1:0] dat_o,
  output logic         full_o,
  output logic         ready_o
);

  logic [W-1:0] dat_q, dat_d;
  logic         full_q, full_d;

  always_comb begin
    dat_d  = dat_q;
    full_d = full_q;
    if (clear_i) full_d = 1'b0;
    if (load_i) begin
      dat_d  = dat_i;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dat_q  <= '0;
      full_q <= 1'b0;
    end else begin
      dat_q  <= dat_d;
      full_q <= full_d;
    end
  end

  assign dat_o   = dat_q;
  assign full_o  = full_q;
  assign ready_o = !full_q;

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: write commits one edge after the later AW/W handshake, reads return one edge after AR.
// Backpressure: AW/W stall while their holding entry is full, AR stalls while a read response is pending.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [NUM_REGS*AXIL_DATA_W-1:0]   reg_out,
  output logic [NUM_REGS-1:0]               wr_pulse
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam int HW_W  = AXIL_STRB_W + AXIL_DATA_W;
  // One extra bit so NUM_REGS == 2**IDX_W still compares correctly.
  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W+1)'(NUM_REGS);

  logic                                   rst_done_q;
  logic [NUM_REGS-1:0][AXIL_DATA_W-1:0]   regs_q, regs_d;
  logic [NUM_REGS-1:0]                    pulse_q, pulse_d;
  logic                                   bvalid_q, bvalid_d;
  axi_resp_t                              bresp_q, bresp_d;
  logic                                   rvalid_q, rvalid_d;
  axi_resp_t                              rresp_q, rresp_d;
  logic [AXIL_DATA_W-1:0]                 rdata_q, rdata_d;

  logic              aw_load, w_load, aw_full, w_full, aw_ready, w_ready;
  logic [IDX_W-1:0]  aw_idx, ar_idx;
  logic [HW_W-1:0]   w_hold;
  logic              commit, aw_in_range, ar_in_range, ar_hs;

  // Address bits [1:0] and protection attributes do not affect decode.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = rst_done_q & aw_ready;
  assign S_AXI_WREADY  = rst_done_q & w_ready;
  assign S_AXI_ARREADY = rst_done_q & !rvalid_q;

  assign aw_load = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_load  = S_AXI_WVALID & S_AXI_WREADY;
  assign commit  = aw_full & w_full & !bvalid_q;
  assign ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;

  axil_hold_reg #(.W(IDX_W)) u_aw_hold (
    .clk_i   (S_AXI_ACLK),
    .rst_ni  (S_AXI_ARESETN),
    .load_i  (aw_load),
    .clear_i (commit),
    .dat_i   (S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]),
    .dat_o   (aw_idx),
    .full_o  (aw_full),
    .ready_o (aw_ready)
  );

  axil_hold_reg #(.W(HW_W)) u_w_hold (
    .clk_i   (S_AXI_ACLK),
    .rst_ni  (S_AXI_ARESETN),
    .load_i  (w_load),
    .clear_i (commit),
    .dat_i   ({S_AXI_WSTRB, S_AXI_WDATA}),
    .dat_o   (w_hold),
    .full_o  (w_full),
    .ready_o (w_ready)
  );

  assign ar_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign aw_in_range = {1'b0, aw_idx} < NUM_REGS_L;
  assign ar_in_range = {1'b0, ar_idx} < NUM_REGS_L;

  always_comb begin
    regs_d   = regs_q;
    pulse_d  = '0;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = aw_in_range ? OKAY : SLVERR;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (aw_idx == IDX_W'(k)) begin
          regs_d[k]  = apply_strb(regs_q[k], w_hold[AXIL_DATA_W-1:0],
                                  w_hold[HW_W-1:AXIL_DATA_W]);
          pulse_d[k] = 1'b1;
        end
      end
    end
  end

  // Read mux uses regs_q, so a same-edge commit is not visible to this read.
  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = ar_in_range ? OKAY : SLVERR;
      rdata_d  = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (ar_idx == IDX_W'(k)) rdata_d = regs_q[k];
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rst_done_q <= 1'b0;
      regs_q     <= '0;
      pulse_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= OKAY;
      rdata_q    <= '0;
    end else begin
      rst_done_q <= 1'b1;
      regs_q     <= regs_d;
      pulse_q    <= pulse_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RDATA  = rdata_q;
  assign reg_out      = regs_q;
  assign wr_pulse     = pulse_q;

endmodule
